// File: rtl/bitnet_seq_pkg.sv
// Shared types and defaults for the layer propagation sequencer.
package bitnet_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FWD      = 3'd1,
        FWD_WAIT = 3'd2,
        BWD      = 3'd3,
        BWD_WAIT = 3'd4,
        DONE     = 3'd5
    } seq_state_t;

    localparam int DEF_NUM_LAYERS    = 4;
    localparam int DEF_SETTLE_CYCLES = 1;
    localparam int DEF_OSC_HALF      = 1;
    localparam int DEF_CNT_W         = 16;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/osc_gen.sv
// Free-running square wave: toggles every OSC_HALF clocks, only reset stops it.
module osc_gen
    import bitnet_seq_pkg::*;
#(
    parameter int OSC_HALF = DEF_OSC_HALF
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic osc_out
);

    localparam int CW = idx_w(OSC_HALF);
    localparam logic [CW-1:0] CNT_LAST = CW'(OSC_HALF - 1);

    logic [CW-1:0] r_cnt;
    logic          r_osc;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cnt <= '0;
            r_osc <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_osc <= ~r_osc;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign osc_out = r_osc;

endmodule

// File: rtl/prop_sequencer.sv
// Steps fd_prop (0..N-1) then, for training samples, bk_prop (N-1..0) strobes.
// Optional statistics counters are built when PROP_SEQ_STATS_EN is defined.
// Handshake: a sample is taken on a clock edge where sample_valid_in and
// sample_ready_out are both high; ready is high exactly while the FSM is IDLE.
module prop_sequencer
    import bitnet_seq_pkg::*;
#(
    parameter int NUM_LAYERS    = DEF_NUM_LAYERS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int OSC_HALF      = DEF_OSC_HALF,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  sample_valid_in,
    input  logic                  train_in,
    input  logic                  abort_in,
    output logic                  sample_ready_out,
    output logic [NUM_LAYERS-1:0] fd_prop_out,
    output logic [NUM_LAYERS-1:0] bk_prop_out,
    output logic                  oscillator_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [CNT_W-1:0]      sample_count_out,
    output logic [2:0]            dbg_state_out
`ifdef PROP_SEQ_STATS_EN
    ,
    output logic [31:0]           stat_busy_cycles_out,
    output logic [15:0]           stat_abort_count_out
`endif
);

    localparam int LAYER_IDX_W = idx_w(NUM_LAYERS);
    localparam int SETTLE_W    = idx_w(SETTLE_CYCLES);
    localparam logic [LAYER_IDX_W-1:0] IDX_LAST    = LAYER_IDX_W'(NUM_LAYERS - 1);
    localparam logic [SETTLE_W-1:0]    SETTLE_LAST =
        SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    seq_state_t            r_state, w_next_state;
    logic [LAYER_IDX_W-1:0] r_idx, w_next_idx;
    logic [SETTLE_W-1:0]    r_settle, w_next_settle;
    logic                   r_train, w_next_train;
    logic                   w_fwd_adv, w_bwd_adv, w_abort;
    logic [NUM_LAYERS-1:0]  w_onehot;

    logic [NUM_LAYERS-1:0]  r_fd, r_bk;
    logic                   r_done, r_busy, r_ready;
    logic [CNT_W-1:0]       r_count;

    assign w_abort  = abort_in && (r_state != IDLE);
    assign w_onehot = NUM_LAYERS'(1) << r_idx;

    always_comb begin
        w_next_state  = r_state;
        w_next_idx    = r_idx;
        w_next_settle = r_settle;
        w_next_train  = r_train;
        w_fwd_adv     = 1'b0;
        w_bwd_adv     = 1'b0;

        case (r_state)
            IDLE: begin
                if (sample_valid_in) begin
                    w_next_state = FWD;
                    w_next_idx   = '0;
                    w_next_train = train_in;
                end
            end
            FWD: begin
                if (SETTLE_CYCLES > 0) begin
                    w_next_state  = FWD_WAIT;
                    w_next_settle = '0;
                end else begin
                    w_fwd_adv = 1'b1;
                end
            end
            FWD_WAIT: begin
                if (r_settle == SETTLE_LAST) w_fwd_adv = 1'b1;
                else                         w_next_settle = r_settle + SETTLE_W'(1);
            end
            BWD: begin
                if (SETTLE_CYCLES > 0) begin
                    w_next_state  = BWD_WAIT;
                    w_next_settle = '0;
                end else begin
                    w_bwd_adv = 1'b1;
                end
            end
            BWD_WAIT: begin
                if (r_settle == SETTLE_LAST) w_bwd_adv = 1'b1;
                else                         w_next_settle = r_settle + SETTLE_W'(1);
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase

        // The backward pass starts on the last layer, so idx is left at N-1.
        if (w_fwd_adv) begin
            if (r_idx == IDX_LAST) begin
                w_next_state = r_train ? BWD : DONE;
            end else begin
                w_next_state = FWD;
                w_next_idx   = r_idx + LAYER_IDX_W'(1);
            end
        end

        if (w_bwd_adv) begin
            if (r_idx == '0) begin
                w_next_state = DONE;
            end else begin
                w_next_state = BWD;
                w_next_idx   = r_idx - LAYER_IDX_W'(1);
            end
        end

        if (w_abort) w_next_state = IDLE;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_settle <= '0;
            r_train  <= 1'b0;
            r_fd     <= '0;
            r_bk     <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_count  <= '0;
        end else begin
            r_state  <= w_next_state;
            r_idx    <= w_next_idx;
            r_settle <= w_next_settle;
            r_train  <= w_next_train;
            // Strobes lag the state by one cycle; an abort squashes the pending one.
            r_fd     <= (r_state == FWD && !w_abort) ? w_onehot : '0;
            r_bk     <= (r_state == BWD && !w_abort) ? w_onehot : '0;
            r_done   <= (r_state == DONE) && !w_abort;
            r_busy   <= (w_next_state != IDLE);
            r_ready  <= (w_next_state == IDLE);
            if (r_state == DONE && !w_abort) r_count <= r_count + CNT_W'(1);
        end
    end

    assign fd_prop_out      = r_fd;
    assign bk_prop_out      = r_bk;
    assign done_out         = r_done;
    assign busy_out         = r_busy;
    assign sample_ready_out = r_ready;
    assign sample_count_out = r_count;
    assign dbg_state_out    = r_state;

    osc_gen #(
        .OSC_HALF (OSC_HALF)
    ) u_osc (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .osc_out (oscillator_out)
    );

`ifdef PROP_SEQ_STATS_EN
    logic [31:0] r_stat_busy;
    logic [15:0] r_stat_abort;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_stat_busy  <= '0;
            r_stat_abort <= '0;
        end else begin
            if (r_state != IDLE && r_stat_busy != '1) r_stat_busy <= r_stat_busy + 32'd1;
            if (w_abort && r_stat_abort != '1)        r_stat_abort <= r_stat_abort + 16'd1;
        end
    end

    assign stat_busy_cycles_out = r_stat_busy;
    assign stat_abort_count_out = r_stat_abort;
`endif

endmodule

// File: tb/tb_prop_sequencer.sv
// Bench for prop_sequencer: dut_a (N=4,S=1,OSC_HALF=1), dut_b (N=4,S=0,OSC_HALF=2,CNT_W=2).
module tb_prop_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, valid_a, train_a, abort_a, ready_a, osc_a, busy_a, done_a;
    logic [3:0] fd_a, bk_a;
    logic [15:0] cnt_a;
    logic [2:0] st_a;
    logic rst_b, valid_b, train_b, abort_b, ready_b, osc_b, busy_b, done_b;
    logic [3:0] fd_b, bk_b;
    logic [1:0] cnt_b;
    logic [2:0] st_b;
`ifdef PROP_SEQ_STATS_EN
    logic [31:0] sb_a, sb_b;
    logic [15:0] sa_a, sa_b;
`endif

    prop_sequencer #(.NUM_LAYERS(4), .SETTLE_CYCLES(1), .OSC_HALF(1), .CNT_W(16)) dut_a (
        .clk_in(clk), .rst_in(rst_a), .sample_valid_in(valid_a), .train_in(train_a),
        .abort_in(abort_a), .sample_ready_out(ready_a), .fd_prop_out(fd_a),
        .bk_prop_out(bk_a), .oscillator_out(osc_a), .busy_out(busy_a), .done_out(done_a),
        .sample_count_out(cnt_a), .dbg_state_out(st_a)
`ifdef PROP_SEQ_STATS_EN
        , .stat_busy_cycles_out(sb_a), .stat_abort_count_out(sa_a)
`endif
    );

    prop_sequencer #(.NUM_LAYERS(4), .SETTLE_CYCLES(0), .OSC_HALF(2), .CNT_W(2)) dut_b (
        .clk_in(clk), .rst_in(rst_b), .sample_valid_in(valid_b), .train_in(train_b),
        .abort_in(abort_b), .sample_ready_out(ready_b), .fd_prop_out(fd_b),
        .bk_prop_out(bk_b), .oscillator_out(osc_b), .busy_out(busy_b), .done_out(done_b),
        .sample_count_out(cnt_b), .dbg_state_out(st_b)
`ifdef PROP_SEQ_STATS_EN
        , .stat_busy_cycles_out(sb_b), .stat_abort_count_out(sa_b)
`endif
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Per-cycle vector {fd[3:0], bk[3:0], done, ready, busy}.
    localparam logic [10:0] IDLE_VEC = 11'b0000_0000_010;
    logic [10:0] qa[$];
    logic [10:0] qb[$];
    int exp_cnt_a = 0;
    int exp_cnt_b = 0;

    // Expected outputs c cycles after the handshake edge, from the latency formulas.
    function automatic logic [10:0] exp_vec(input int s, input bit tr, input int c);
        logic [3:0] fd, bk;
        logic done, rdy, busy;
        int p, fend, l;
        p = 1 + s;
        fend = 4 * p;
        l = tr ? 2 * fend + 1 : fend + 1;
        fd = '0; bk = '0; done = 1'b0; rdy = 1'b0; busy = 1'b1;
        if (c >= 1 && c <= fend && (c - 1) % p == 0) fd[(c - 1) / p] = 1'b1;
        if (tr && c > fend && c <= 2 * fend && (c - fend - 1) % p == 0)
            bk[3 - (c - fend - 1) / p] = 1'b1;
        if (c == l) begin done = 1'b1; rdy = 1'b1; busy = 1'b0; end
        return {fd, bk, done, rdy, busy};
    endfunction

    always @(negedge clk) begin : mon_a
        logic [10:0] v;
        if (!rst_a) begin
            v = (qa.size() > 0) ? qa.pop_front() : IDLE_VEC;
            chk("seq_a", {21'd0, fd_a, bk_a, done_a, ready_a, busy_a}, {21'd0, v});
        end
    end

    always @(negedge clk) begin : mon_b
        logic [10:0] v;
        if (!rst_b) begin
            v = (qb.size() > 0) ? qb.pop_front() : IDLE_VEC;
            chk("seq_b", {21'd0, fd_b, bk_b, done_b, ready_b, busy_b}, {21'd0, v});
        end
    end

    // Oscillator model: edges since reset release, divided by half-period.
    int cyc_a, cyc_b;
    always @(posedge clk or posedge rst_a) if (rst_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;
    always @(posedge clk or posedge rst_b) if (rst_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;
    always @(negedge clk) begin
        if (!rst_a) chk("osc_a", {31'd0, osc_a}, 32'(cyc_a % 2));
        if (!rst_b) chk("osc_b", {31'd0, osc_b}, 32'((cyc_b / 2) % 2));
    end

    task automatic run_sample(input bit sel, input bit tr, input int abort_at, input int lat);
        int s;
        int endc;
        s = sel ? 0 : 1;
        endc = (abort_at >= 0) ? abort_at : lat;
        @(posedge clk); #1;
        if (sel) begin valid_b = 1'b1; train_b = tr; end
        else     begin valid_a = 1'b1; train_a = tr; end
        @(posedge clk); #1;
        if (sel) valid_b = 1'b0; else valid_a = 1'b0;
        for (int c = 0; c <= endc; c++) begin
            if (sel) qb.push_back(exp_vec(s, tr, c)); else qa.push_back(exp_vec(s, tr, c));
        end
        if (abort_at < 0) begin
            if (sel) exp_cnt_b++; else exp_cnt_a++;
        end
        for (int c = 0; c <= endc; c++) begin
            if (sel) abort_b = (c == abort_at); else abort_a = (c == abort_at);
            @(posedge clk); #1;
        end
        abort_a = 1'b0;
        abort_b = 1'b0;
        if (sel) begin
            chk("ready_b_after", {31'd0, ready_b}, 32'd1);
            chk("count_b", {30'd0, cnt_b}, 32'(exp_cnt_b % 4));
        end else begin
            chk("ready_a_after", {31'd0, ready_a}, 32'd1);
            chk("count_a", {16'd0, cnt_a}, 32'(exp_cnt_a % 65536));
        end
    endtask

    typedef struct {
        bit tr;
        int abort_at;
        int lat;
    } vec_t;
    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b0, -1, 9};
        tbl[1] = '{1'b1, -1, 17};
        tbl[2] = '{1'b1, 4, 17};
        tbl[3] = '{1'b0, 2, 9};
        tbl[4] = '{1'b1, 16, 17};
        tbl[5] = '{1'b0, 8, 9};
        tbl[6] = '{1'b1, int'($urandom_range(0, 16)), 17};

        rst_a = 1'b1; rst_b = 1'b1;
        valid_a = 1'b0; train_a = 1'b0; abort_a = 1'b0;
        valid_b = 1'b0; train_b = 1'b0; abort_b = 1'b0;
        #3;
        chk("rst_ready_a", {31'd0, ready_a}, 32'd1);
        chk("rst_outs_a", {21'd0, fd_a, bk_a, done_a, busy_a, osc_a}, 32'd0);
        chk("rst_count_a", {16'd0, cnt_a}, 32'd0);
        chk("rst_state_a", {29'd0, st_a}, 32'd0);
        chk("rst_ready_b", {31'd0, ready_b}, 32'd1);
        chk("rst_outs_b", {21'd0, fd_b, bk_b, done_b, busy_b, osc_b}, 32'd0);
        repeat (3) @(posedge clk);
        #1; rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++) run_sample(1'b0, tbl[i].tr, tbl[i].abort_at, tbl[i].lat);

        // Asynchronous reset in the middle of the backward pass.
        @(posedge clk); #1; valid_a = 1'b1; train_a = 1'b1;
        @(posedge clk); #1; valid_a = 1'b0;
        for (int c = 0; c <= 17; c++) qa.push_back(exp_vec(1, 1'b1, c));
        repeat (11) @(posedge clk);
        #3;
        rst_a = 1'b1;
        qa.delete();
        exp_cnt_a = 0;
        #1;
        chk("midrst_outs_a", {21'd0, fd_a, bk_a, done_a, busy_a, osc_a}, 32'd0);
        chk("midrst_ready_a", {31'd0, ready_a}, 32'd1);
        chk("midrst_count_a", {16'd0, cnt_a}, 32'd0);
        repeat (2) @(posedge clk);
        #1; rst_a = 1'b0;
        chk("rel_ready_a", {31'd0, ready_a}, 32'd1);
        run_sample(1'b0, 1'b0, -1, 9);

        // Zero settle, valid held high: three samples back to back.
        @(posedge clk); #1; valid_b = 1'b1; train_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            for (int c = 0; c <= 5; c++) qb.push_back(exp_vec(0, 1'b0, c));
            exp_cnt_b++;
            repeat (5) @(posedge clk);
            #1;
            chk("b2b_count_b", {30'd0, cnt_b}, 32'(exp_cnt_b % 4));
        end
        valid_b = 1'b0;
        @(posedge clk); #1;
        chk("b2b_final_b", {30'd0, cnt_b}, 32'd3);
        run_sample(1'b1, 1'b0, -1, 5);
        run_sample(1'b1, 1'b1, -1, 9);

        repeat (6) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
